data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous data RAM between two requesters: the processor
//  data port (cpu_*) and an external master (ext_*), e.g. a debug loader or DMA.
//  The CPU has priority. A starvation counter guarantees the external master one
//  grant after CPU_BURST_MAX consecutive contested CPU grants.
//  Read data is returned one cycle after the grant, tagged to the requester that won.
// PARAMETERS
//  ADDR_SIZE      18  address width of both requesters and the RAM
//  WORD_SIZE      18  data word width
//  CPU_BURST_MAX  4   max consecutive contested CPU grants before ext is forced; legal range >=1
// PORTS
//  clock       in   1          single clock; all state updates on posedge
//  reset       in   1          synchronous, active-high
//  cpu_req     in   1          CPU access request; held until cpu_gnt
//  cpu_we      in   1          1=write, 0=read; valid with cpu_req
//  cpu_addr    in   ADDR_SIZE  CPU word address
//  cpu_wdata   in   WORD_SIZE  CPU write data
//  cpu_gnt     out  1          comb; CPU access performed this cycle
//  cpu_rvalid  out  1          reg; cpu_rdata valid (cycle after a CPU read grant)
//  cpu_rdata   out  WORD_SIZE  read data for the CPU
//  ext_req     in   1          external request; held until ext_gnt
//  ext_we      in   1          1=write, 0=read
//  ext_addr    in   ADDR_SIZE  external word address
//  ext_wdata   in   WORD_SIZE  external write data
//  ext_gnt     out  1          comb; external access performed this cycle
//  ext_rvalid  out  1          reg; ext_rdata valid
//  ext_rdata   out  WORD_SIZE  read data for the external master
//  mem_we      out  1          RAM write enable
//  mem_addr    out  ADDR_SIZE  RAM address
//  mem_wdata   out  WORD_SIZE  RAM write data
//  mem_rdata   in   WORD_SIZE  RAM read data; valid the cycle after the address is presented
// BEHAVIOUR
//  - Reset (while reset=1): cpu_gnt=ext_gnt=0, mem_we=0, both rvalid=0, cnt=0.
//    Any read in flight is discarded; no rvalid is issued for it after reset drops.
//  - Grant is combinational from req and registered cnt. At most one grant per cycle.
//    * Only cpu_req: grant CPU. Only ext_req: grant ext. Neither: no grant, mem_we=0.
//    * Both, cnt<CPU_BURST_MAX: grant CPU, cnt<=cnt+1.
//    * Both, cnt==CPU_BURST_MAX: grant ext, cnt<=0.
//    * Any ext grant clears cnt. A CPU grant without contention leaves cnt unchanged.
//    * cnt width is $clog2(CPU_BURST_MAX+1). cnt saturates at CPU_BURST_MAX and never wraps.
//  - mem_addr/mem_wdata/mem_we come from the winner in the grant cycle.
//    With no grant: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
//  - Write: RAM is written at the grant clock edge. No rvalid is issued. Latency is 0 (gnt same cycle).
//  - Read: rvalid is asserted exactly 1 cycle after the grant, for 1 cycle, on the winner's port.
//    The owner is stored in a register at the grant edge. {cpu,ext}_rdata = mem_rdata on that cycle.
//    Outside rvalid, rdata values are don't-care.
//  - Back-to-back grants are allowed every cycle. A read grant in cycle N and a new grant in N+1
//    both proceed, and rvalid for N appears in N+1.
//  - A requester that drops req before gnt is simply not served. Changing we/addr/wdata
//    while req=1 and gnt=0 is legal; the values in the grant cycle are used.
// TESTING
//  1 Reset: hold reset 3 cycles with both req=1 -> gnt=0, mem_we=0, rvalid=0 every cycle.
//  2 CPU write 0x155 @addr 5, then read @5 -> cpu_gnt same cycle each;
//    cpu_rvalid=1, cpu_rdata=0x155 exactly 1 cycle after the read grant; ext_rvalid stays 0.
//  3 Contention, CPU_BURST_MAX=4, both reading every cycle -> grants C,C,C,C,E,C,C,C,C,E...
//    Each rvalid lands on the right port with RAM contents for its own address.
//  4 Ext write 0x3FFFF @0x20 while cpu_req=0 -> ext_gnt=1, mem_we=1, mem_addr=0x20;
//    a later CPU read @0x20 returns 0x3FFFF.
//  5 Mixed: ext read granted in cycle N, CPU write granted in N+1 -> ext_rvalid in N+1, cpu_rvalid stays 0.
//  6 Reset asserted in the cycle after a CPU read grant -> no cpu_rvalid then or after; cnt returns to 0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the signals around the shared data RAM arbiter.
//   cpu_*  : processor data port (request side, grant and read return)
//   ext_*  : external master port (debug loader / DMA)
//   mem_*  : single-port synchronous RAM port
// Modports:
//   slave  : the arbiter itself (takes requests, drives grants and the RAM port)
//   master : the environment (requesters plus the RAM read data)
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18
);

  // CPU requester
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;
  logic [WORD_SIZE-1:0] cpu_rdata;

  // External requester
  logic                 ext_req;
  logic                 ext_we;
  logic [ADDR_SIZE-1:0] ext_addr;
  logic [WORD_SIZE-1:0] ext_wdata;
  logic                 ext_gnt;
  logic                 ext_rvalid;
  logic [WORD_SIZE-1:0] ext_rdata;

  // RAM port
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU data port and an
// external master. The CPU has priority; after CPU_BURST_MAX consecutive
// contested CPU grants the external master is granted once. Read data returns
// one cycle after the grant on the port of the requester that won.
// Ports:
//   clock : single clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : data_mem_arbiter_if.slave (cpu_*, ext_*, mem_* signals)
module data_mem_arbiter #(
  parameter int unsigned ADDR_SIZE     = 18,
  parameter int unsigned WORD_SIZE     = 18,
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_arbiter_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(CPU_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_BURST_MAX);

  // Owner of the read data arriving from the RAM this cycle.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_CPU,
    RD_EXT
  } rd_state_t;

  rd_state_t        rd_state;
  rd_state_t        rd_state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic contested;
  logic force_ext;
  logic cpu_gnt;
  logic ext_gnt;

  // ---------------------------------------------------------------------------
  // Grant decision: purely combinational from the requests and the registered
  // starvation counter. Reset suppresses every grant so nothing touches the RAM.
  // ---------------------------------------------------------------------------
  always_comb begin
    contested = bus.cpu_req && bus.ext_req;
    force_ext = contested && (cnt == CNT_MAX);
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    if (!reset) begin
      cpu_gnt = bus.cpu_req && !force_ext;
      ext_gnt = bus.ext_req && (!bus.cpu_req || force_ext);
    end
  end

  // Starvation counter: counts contested CPU wins, cleared by any ext grant,
  // untouched by uncontested CPU grants. It never passes CNT_MAX because a
  // contested cycle at CNT_MAX always goes to the external master.
  always_comb begin
    cnt_next = cnt;
    if (ext_gnt) begin
      cnt_next = '0;
    end else if (cpu_gnt && contested && (cnt != CNT_MAX)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port: driven by the winner; with no grant the CPU side is presented
  // with the write enable forced low.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (ext_gnt) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end else if (cpu_gnt) begin
      bus.mem_we = bus.cpu_we;
    end
  end

  always_comb begin
    bus.cpu_gnt = cpu_gnt;
    bus.ext_gnt = ext_gnt;
  end

  // ---------------------------------------------------------------------------
  // Read-return tracking: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= RD_NONE;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  // Every cycle is independent: the owner of next cycle's data is decided only
  // by this cycle's grant, so back-to-back reads need no extra state.
  always_comb begin
    rd_state_next = RD_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_state_next = RD_CPU;
    end else if (ext_gnt && !bus.ext_we) begin
      rd_state_next = RD_EXT;
    end
  end

  // The registered owner is masked by reset so a read granted in the cycle
  // before reset rises never surfaces as rvalid while reset is held.
  always_comb begin
    bus.cpu_rvalid = (rd_state == RD_CPU) && !reset;
    bus.ext_rvalid = (rd_state == RD_EXT) && !reset;
    bus.cpu_rdata  = bus.mem_rdata;
    bus.ext_rdata  = bus.mem_rdata;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a behavioural synchronous RAM.
module tb_data_mem_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  data_mem_arbiter_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();

  data_mem_arbiter #(
    .ADDR_SIZE    (18),
    .WORD_SIZE    (18),
    .CPU_BURST_MAX(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-before-write, unwritten words read 0.
  logic [17:0] ram [logic [17:0]];
  always @(posedge clock) begin
    bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 18'h0;
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
  end

  // Inputs change 1 time unit after posedge, outputs are checked at negedge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    bus.cpu_req = 1; bus.ext_req = 1; bus.cpu_we = 1; bus.ext_we = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_we, bus.cpu_rvalid, bus.ext_rvalid} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: gnt/we/rvalid=%b required 00000", i,
                 {bus.cpu_gnt, bus.ext_gnt, bus.mem_we, bus.cpu_rvalid, bus.ext_rvalid});
      end
      next_cycle();
    end
    reset = 0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 18'd5; bus.cpu_wdata = 18'h155;
    settle();
    checks++;
    if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_we} !== 3'b101 || bus.mem_addr !== 18'd5 ||
        bus.mem_wdata !== 18'h155) begin
      failures++;
      $display("FAIL cpu_write: gnt/ext/we=%b addr=%h data=%h required 101 5 155",
               {bus.cpu_gnt, bus.ext_gnt, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    bus.cpu_we = 0;
    settle();
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_grant: gnt=%b we=%b rvalid=%b required 1 0 0",
               bus.cpu_gnt, bus.mem_we, bus.cpu_rvalid);
    end
    next_cycle();
    idle_inputs();
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 18'h155 || bus.ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h ext_rvalid=%b required 1 155 0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.ext_rvalid);
    end
    next_cycle();
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_rvalid_pulse: rvalid=%b required 0", bus.cpu_rvalid);
    end
    next_cycle();
  endtask

  // Both requesters read every cycle: C,C,C,C,E,C,C,C,C,E.
  task automatic test_contention();
    logic [9:0]  exp_ext = 10'b1000010000;  // bit i set: ext wins cycle i
    logic        prev_valid;
    logic        prev_ext;
    logic [17:0] prev_data;
    for (int unsigned i = 0; i < 10; i++) begin
      ram[18'h40 + 18'(i)] = 18'h100 + 18'(i);
      ram[18'h80 + 18'(i)] = 18'h200 + 18'(i);
    end
    prev_valid = 0; prev_ext = 0; prev_data = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (i < 10) begin
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 18'h40 + 18'(i);
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 18'h80 + 18'(i);
      end else begin
        idle_inputs();
      end
      settle();
      if (i < 10) begin
        checks++;
        if (bus.ext_gnt !== exp_ext[i] || bus.cpu_gnt !== !exp_ext[i] ||
            bus.mem_addr !== (exp_ext[i] ? 18'h80 + 18'(i) : 18'h40 + 18'(i))) begin
          failures++;
          $display("FAIL contention_grant cycle %0d: cpu_gnt=%b ext_gnt=%b addr=%h required ext_gnt=%b",
                   i, bus.cpu_gnt, bus.ext_gnt, bus.mem_addr, exp_ext[i]);
        end
      end
      if (prev_valid) begin
        checks++;
        if (bus.cpu_rvalid !== !prev_ext || bus.ext_rvalid !== prev_ext ||
            (prev_ext ? bus.ext_rdata : bus.cpu_rdata) !== prev_data) begin
          failures++;
          $display("FAIL contention_rdata cycle %0d: cpu_rv=%b ext_rv=%b cpu_rd=%h ext_rd=%h required ext=%b data=%h",
                   i, bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_rdata, bus.ext_rdata, prev_ext, prev_data);
        end
      end
      if (i < 10) begin
        prev_valid = 1;
        prev_ext   = exp_ext[i];
        prev_data  = exp_ext[i] ? 18'h200 + 18'(i) : 18'h100 + 18'(i);
      end
      next_cycle();
    end
  endtask

  task automatic test_ext_write();
    bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 18'h20; bus.ext_wdata = 18'h3FFFF;
    settle();
    checks++;
    if ({bus.ext_gnt, bus.cpu_gnt, bus.mem_we} !== 3'b101 || bus.mem_addr !== 18'h20 ||
        bus.mem_wdata !== 18'h3FFFF) begin
      failures++;
      $display("FAIL ext_write: ext/cpu/we=%b addr=%h data=%h required 101 20 3ffff",
               {bus.ext_gnt, bus.cpu_gnt, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    idle_inputs();
    bus.cpu_req = 1; bus.cpu_addr = 18'h20;
    settle();
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL ext_write_readback_grant: cpu_gnt=%b ext_rvalid=%b required 1 0",
               bus.cpu_gnt, bus.ext_rvalid);
    end
    next_cycle();
    idle_inputs();
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 18'h3FFFF) begin
      failures++;
      $display("FAIL ext_write_readback: rvalid=%b rdata=%h required 1 3ffff",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 18'h81;   // holds 0x201
    settle();
    checks++;
    if (bus.ext_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ext_read_grant: ext_gnt=%b we=%b required 1 0", bus.ext_gnt, bus.mem_we);
    end
    next_cycle();
    idle_inputs();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 18'd7; bus.cpu_wdata = 18'h0AB;
    settle();
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.ext_rvalid !== 1'b1 ||
        bus.ext_rdata !== 18'h201 || bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mixed: cpu_gnt=%b we=%b ext_rv=%b ext_rd=%h cpu_rv=%b required 1 1 1 201 0",
               bus.cpu_gnt, bus.mem_we, bus.ext_rvalid, bus.ext_rdata, bus.cpu_rvalid);
    end
    next_cycle();
    idle_inputs();
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after_write: cpu_rv=%b ext_rv=%b required 0 0", bus.cpu_rvalid, bus.ext_rvalid);
    end
    next_cycle();
  endtask

  // Counter is raised to 2, a CPU read is cut by reset, then the full
  // C,C,C,C,E pattern must reappear (a surviving count would give C,C,E).
  task automatic test_reset_mid_read();
    logic [4:0] exp_ext = 5'b10000;
    for (int unsigned i = 0; i < 2; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 0; bus.ext_req = 1; bus.ext_we = 0;
      next_cycle();
    end
    idle_inputs();
    bus.cpu_req = 1; bus.cpu_addr = 18'd5;
    settle();
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_grant: cpu_gnt=%b required 1", bus.cpu_gnt);
    end
    next_cycle();
    idle_inputs();
    reset = 1;
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rvalid_in_reset: rvalid=%b required 0", bus.cpu_rvalid);
    end
    next_cycle();
    reset = 0;
    settle();
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rvalid_after: cpu_rv=%b ext_rv=%b required 0 0", bus.cpu_rvalid, bus.ext_rvalid);
    end
    next_cycle();
    for (int unsigned i = 0; i < 5; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 0; bus.ext_req = 1; bus.ext_we = 0;
      settle();
      checks++;
      if (bus.ext_gnt !== exp_ext[i] || bus.cpu_gnt !== !exp_ext[i]) begin
        failures++;
        $display("FAIL rst_cnt_cleared cycle %0d: cpu_gnt=%b ext_gnt=%b required ext_gnt=%b",
                 i, bus.cpu_gnt, bus.ext_gnt, exp_ext[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1;
    idle_inputs();
    next_cycle();
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_ext_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
